// File: rtl/cla_vector_checker_pkg.sv
// Shared state encoding and defaults for the CLA vector checker.
package cla_vector_checker_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 16;

  // Width of a down-counter that must hold n-1; never narrower than one bit.
  function automatic int settle_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cla_vector_checker_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module cla_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Count on inc until the counter reaches all-ones, then hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/cla_vector_checker.sv
// Stimulus-apply / response-check engine for a gate-level CLA adder.
// Accepts a vector, drives it, waits SETTLE_CYCLES, then compares the
// adder result against a behavioural a+b+cin and keeps pass/error counts.
module cla_vector_checker
  import cla_vector_checker_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [WIDTH-1:0] vec_a,
  input  logic [WIDTH-1:0] vec_b,
  input  logic             vec_cin,
  input  logic             vec_last,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  output logic             dut_cin,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             mismatch,
  output logic [WIDTH-1:0] exp_sum,
  output logic             exp_cout,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic             done
);

  localparam int SC_W = settle_w(SETTLE_CYCLES);

  state_t          state, state_nxt;
  logic [SC_W-1:0] settle_cnt;
  logic            last_q;
  logic            accept;
  logic            in_cmp;

  assign accept = vec_valid & vec_ready;
  assign in_cmp = (state == COMPARE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake/status decode.
  always_comb begin
    state_nxt = state;
    vec_ready = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        vec_ready = 1'b1;
        if (vec_valid) state_nxt = SETTLE;
      end
      SETTLE:  if (settle_cnt == '0) state_nxt = COMPARE;
      COMPARE: state_nxt = last_q ? DONE : IDLE;
      DONE:    done = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  // Result check; case inequality so X/Z from the adder is flagged as an error.
  always_comb begin
    mismatch = 1'b0;
    if (in_cmp) mismatch = ({dut_cout, dut_sum} !== {exp_cout, exp_sum});
  end

  // Operand drive, expected result, last flag and settle countdown.
  // Drive/expected registers are left alone after COMPARE for waveform debug.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dut_a      <= '0;
      dut_b      <= '0;
      dut_cin    <= 1'b0;
      exp_sum    <= '0;
      exp_cout   <= 1'b0;
      last_q     <= 1'b0;
      settle_cnt <= '0;
    end else if (accept) begin
      dut_a                 <= vec_a;
      dut_b                 <= vec_b;
      dut_cin               <= vec_cin;
      {exp_cout, exp_sum}   <= {1'b0, vec_a} + {1'b0, vec_b} + (WIDTH+1)'(vec_cin);
      last_q                <= vec_last;
      settle_cnt            <= SC_W'(SETTLE_CYCLES - 1);
    end else if (state == SETTLE && settle_cnt != '0) begin
      settle_cnt <= settle_cnt - SC_W'(1);
    end
  end

  cla_sat_counter #(.CNT_W(CNT_W)) u_vec_cnt (
    .clk (clk),
    .rst (rst),
    .inc (in_cmp),
    .cnt (vec_count)
  );

  cla_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (mismatch),
    .cnt (err_count)
  );

endmodule

// File: tb/tb_cla_vector_checker.sv
// Randomised bench for cla_vector_checker with a behavioural timing/result model.
module tb_cla_vector_checker;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vec_valid = 1'b0;
  logic [15:0] vec_a = '0, vec_b = '0;
  logic        vec_cin = 1'b0, vec_last = 1'b0;
  logic [15:0] stuck_mask = '0;

  // main checker (CNT_W=16) driving a correct adder with stuck-at-0 injection
  logic        vec_ready, dut_cin, dut_cout, mismatch, exp_cout, done;
  logic [15:0] dut_a, dut_b, dut_sum, exp_sum, vec_count, err_count;
  logic [16:0] add1;
  // second checker (CNT_W=2) on an adder whose sum bit 0 is always inverted
  logic        vec_ready2, dut2_cin, dut2_cout, mismatch2, exp_cout2, done2;
  logic [15:0] dut2_a, dut2_b, dut2_sum, exp_sum2;
  logic [1:0]  vec_count2, err_count2;
  logic [16:0] add2;

  assign add1      = {1'b0, dut_a} + {1'b0, dut_b} + 17'(dut_cin);
  assign dut_sum   = add1[15:0] & ~stuck_mask;
  assign dut_cout  = add1[16];
  assign add2      = {1'b0, dut2_a} + {1'b0, dut2_b} + 17'(dut2_cin);
  assign dut2_sum  = add2[15:0] ^ 16'h0001;
  assign dut2_cout = add2[16];

  cla_vector_checker #(.WIDTH(16), .SETTLE_CYCLES(S), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_a(vec_a), .vec_b(vec_b), .vec_cin(vec_cin), .vec_last(vec_last),
    .dut_a(dut_a), .dut_b(dut_b), .dut_cin(dut_cin),
    .dut_sum(dut_sum), .dut_cout(dut_cout), .mismatch(mismatch),
    .exp_sum(exp_sum), .exp_cout(exp_cout),
    .vec_count(vec_count), .err_count(err_count), .done(done)
  );

  cla_vector_checker #(.WIDTH(16), .SETTLE_CYCLES(S), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .vec_valid(vec_valid), .vec_ready(vec_ready2),
    .vec_a(vec_a), .vec_b(vec_b), .vec_cin(vec_cin), .vec_last(vec_last),
    .dut_a(dut2_a), .dut_b(dut2_b), .dut_cin(dut2_cin),
    .dut_sum(dut2_sum), .dut_cout(dut2_cout), .mismatch(mismatch2),
    .exp_sum(exp_sum2), .exp_cout(exp_cout2),
    .vec_count(vec_count2), .err_count(err_count2), .done(done2)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0, cyc = 0, n_pulse = 0, n_sent = 0, acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_t: clocks since the current vector was accepted (-1 = none in flight).
  int          m_t = -1;
  bit          m_done = 1'b0;
  logic [15:0] m_a = '0, m_b = '0;
  logic        m_cin = 1'b0, m_last = 1'b0;
  logic [16:0] m_exp = '0;
  int          m_vec = 0, m_err = 0;

  function automatic bit wrong1(input logic [15:0] a, b, input logic cin, input logic [15:0] mask);
    logic [16:0] t;
    t = {1'b0, a} + {1'b0, b} + 17'(cin);
    return (t[15:0] & ~mask) != t[15:0];
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_t = -1; m_done = 1'b0; m_a = '0; m_b = '0; m_cin = 1'b0;
      m_last = 1'b0; m_exp = '0; m_vec = 0; m_err = 0;
    end else if (m_t == S) begin
      m_vec++;
      if (wrong1(m_a, m_b, m_cin, stuck_mask)) m_err++;
      m_t = -1;
      m_done = m_last;
    end else if (m_t >= 0) begin
      m_t++;
    end else if (!m_done && vec_valid) begin
      m_a = vec_a; m_b = vec_b; m_cin = vec_cin; m_last = vec_last;
      m_exp = {1'b0, vec_a} + {1'b0, vec_b} + 17'(vec_cin);
      m_t = 0;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    bit rdy, cmp;
    rdy = (m_t < 0) && !m_done;
    cmp = (m_t == S);
    if (mismatch) n_pulse++;
    chk("vec_ready", vec_ready, rdy);
    chk("done", done, m_done);
    chk("mismatch", mismatch, cmp && wrong1(m_a, m_b, m_cin, stuck_mask));
    chk("dut_ab", {dut_a, dut_b}, {m_a, m_b});
    chk("dut_cin", dut_cin, m_cin);
    chk("exp", {exp_cout, exp_sum}, m_exp);
    chk("vec_count", vec_count, sat(m_vec, 65535));
    chk("err_count", err_count, sat(m_err, 65535));
    chk("vec_ready2", vec_ready2, rdy);
    chk("mismatch2", mismatch2, cmp);
    chk("vec_count2", vec_count2, sat(m_vec, 3));
    chk("err_count2", err_count2, sat(m_vec, 3));
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [15:0] a, b, input logic cin, last);
    bit ok = 1'b0;
    vec_valid = 1'b1; vec_a = a; vec_b = b; vec_cin = cin; vec_last = last;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (vec_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
    end
    acc_cyc = cyc;
    vec_valid = 1'b0;
    if (ok) n_sent++;
    else begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: got no accept expected accept within 40 clks");
    end
  endtask

  task automatic wait_cmp();
    repeat (S + 1) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_sent = 0;
  endtask

  initial begin
    int c0, c1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", vec_ready, 1);
    chk("rst_count", vec_count, 0);
    chk("rst_dut_a", dut_a, 0);
    rst = 1'b0;

    // carry out of the top bit
    send(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    wait_cmp();
    chk("ff_exp_sum", exp_sum, 32'hFFFE);
    chk("ff_exp_cout", exp_cout, 1);
    chk("ff_vec_count", vec_count, 1);
    chk("ff_err_count", err_count, 0);

    // full wrap-around
    send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    wait_cmp();
    chk("wrap_exp_sum", exp_sum, 32'hFFFF);
    chk("wrap_exp_cout", exp_cout, 1);

    // sum bit 0 stuck at 0
    n_pulse = 0;
    stuck_mask = 16'h0001;
    send(16'd1, 16'd0, 1'b0, 1'b0);
    wait_cmp();
    chk("stuck_pulses", n_pulse, 1);
    chk("stuck_err_count", err_count, 1);
    stuck_mask = '0;

    // back-to-back with valid held
    send(16'd10, 16'd20, 1'b0, 1'b0); c0 = acc_cyc;
    send(16'd30, 16'd40, 1'b1, 1'b0); c1 = acc_cyc;
    chk("b2b_space1", c1 - c0, S + 2);
    send(16'd50, 16'd60, 1'b0, 1'b0);
    chk("b2b_space2", acc_cyc - c1, S + 2);
    wait_cmp();

    // random vectors with occasional stuck bits and gaps
    for (int i = 0; i < 40; i++) begin
      logic [15:0] a, b;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      stuck_mask = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
      a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      send(a, b, 1'($urandom), 1'b0);
    end
    wait_cmp();
    stuck_mask = '0;
    chk("sat_vec_count2", vec_count2, 3);
    chk("sat_err_count2", err_count2, 3);

    // last vector then a refused third offer
    send(16'd1, 16'd2, 1'b0, 1'b0);
    send(16'd3, 16'd4, 1'b0, 1'b1);
    wait_cmp();
    vec_valid = 1'b1; vec_a = 16'd99; vec_b = 16'd1; vec_last = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    vec_valid = 1'b0;
    chk("last_done", done, 1);
    chk("last_ready", vec_ready, 0);
    chk("last_count", vec_count, n_sent);
    chk("last_exp_sum", exp_sum, 7);

    // reset clears DONE
    do_reset();
    chk("rst2_ready", vec_ready, 1);
    chk("rst2_done", done, 0);
    chk("rst2_count", vec_count, 0);

    // reset mid-SETTLE aborts the vector
    send(16'd5, 16'd6, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    chk("abort_count", vec_count, 0);
    chk("abort_ready", vec_ready, 1);
    chk("abort_dut_a", dut_a, 0);
    chk("abort_exp_sum", exp_sum, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    n_sent = 0;
    send(16'd7, 16'd8, 1'b1, 1'b0);
    wait_cmp();
    chk("post_abort_count", vec_count, 1);
    chk("post_abort_exp", {exp_cout, exp_sum}, 16);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish by 500000");
    $fatal(1, "timeout");
  end

endmodule
